// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit unsigned multiply/divide unit placed between the
// register file read ports (RD1/RD2) and the write port (A3/WD3).
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset, aborts any operation in flight
//   start    - request a new operation (only looked at while idle)
//   op       - 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_val  - operand A (multiplicand / dividend)
//   rs2_val  - operand B (multiplier / divisor)
//   rd_addr  - destination register, captured on accept
//   busy     - high from the cycle after accept through the done cycle
//   done     - one-cycle completion pulse
//   wb_en    - register file write request, only ever high with done
//   wb_addr  - captured rd_addr
//   result   - operation result, held until the next completion
//
// Build option: define MULDIV_DIV_EN to include the restoring divider. Without
// it, DIVU/REMU complete one cycle after accept with result 0 and no write-back.

module muldiv_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   result
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [5:0] LastIter = 6'(XLEN - 1);

    state_e              state_q;
    logic [1:0]          op_q;
    logic [5:0]          cnt_q;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [XLEN-1:0]     opnd_q;
    // Shift-add accumulator: upper half partial product, lower half the
    // not-yet-consumed multiplier bits.
    logic [2*XLEN-1:0]   acc_q;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   acc_new;
    logic [XLEN-1:0]     calc_res;

    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign acc_new = {mul_sum, acc_q[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
    // Restored remainder is always below the divisor, so XLEN bits hold it.
    logic [XLEN-1:0]     rem_q;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [XLEN-1:0]     quo_q;
    logic [XLEN:0]       rem_sh;
    logic                rem_ge;
    logic [XLEN:0]       rem_new;
    logic [XLEN-1:0]     quo_new;
    logic                rem_unused;

    assign rem_sh     = {rem_q, quo_q[XLEN-1]};
    assign rem_ge     = rem_sh >= {1'b0, opnd_q};
    assign rem_new    = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    assign quo_new    = {quo_q[XLEN-2:0], rem_ge};
    // Top bit of the restored value is always zero.
    assign rem_unused = rem_new[XLEN];
`endif

    // Result of the final iteration, picked from the post-step datapath values.
    always_comb begin
        calc_res = '0;
        case (op_q)
            2'b00:   calc_res = acc_new[XLEN-1:0];
            2'b01:   calc_res = acc_new[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            2'b10:   calc_res = quo_new;
            2'b11:   calc_res = rem_new[XLEN-1:0];
`endif
            default: calc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
`ifdef MULDIV_DIV_EN
            rem_q   <= '0;
            quo_q   <= '0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            result  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        wb_addr <= rd_addr;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        if (!op[1]) begin
                            opnd_q  <= rs1_val;
                            acc_q   <= {{XLEN{1'b0}}, rs2_val};
                            state_q <= StCalc;
`ifdef MULDIV_DIV_EN
                        end else if (rs2_val == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            result  <= op[0] ? rs1_val : '1;
                            done    <= 1'b1;
                            wb_en   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            opnd_q  <= rs2_val;
                            quo_q   <= rs1_val;
                            rem_q   <= '0;
                            state_q <= StCalc;
                        end
`else
                        end else begin
                            // No divider: finish at once without touching the register file.
                            result  <= '0;
                            done    <= 1'b1;
                            wb_en   <= 1'b0;
                            state_q <= StDone;
                        end
`endif
                    end
                end
                StCalc: begin
`ifdef MULDIV_DIV_EN
                    if (op_q[1]) begin
                        rem_q <= rem_new[XLEN-1:0];
                        quo_q <= quo_new;
                    end else begin
                        acc_q <= acc_new;
                    end
`else
                    acc_q <= acc_new;
`endif
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LastIter) begin
                        result  <= calc_res;
                        done    <= 1'b1;
                        wb_en   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    wb_en   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
